// File: rtl/nrisc_mem_pkg.sv
// Shared constants and port state encoding for the NRISC dual-core data memory.
package nrisc_mem_pkg;
  localparam int TAM        = 16;
  localparam int Lmem       = 8;
  localparam int SHARED_BIT = Lmem;
  localparam int GPIN_IDX   = 0;
  localparam int GPOUT_IDX  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } port_state_e;
endpackage

// File: rtl/mem_addr_check.sv
// Combinational data-memory address screen: shared/private decode and illegal-access flag.
module mem_addr_check
  import nrisc_mem_pkg::*;
#(
  parameter int AW = TAM,
  parameter int LW = Lmem
) (
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic          is_shared,
  output logic          illegal
);
  logic [AW-1:0] gpin_addr;
  logic          out_of_range;

  // GPIN is rewritten by the memory every cycle, so a store there would be lost
  assign gpin_addr    = (AW'(1) << LW) | AW'(GPIN_IDX);
  assign out_of_range = |addr[AW-1:LW+1];
  assign is_shared    = addr[LW];
  assign illegal      = out_of_range | (we & (addr == gpin_addr));
endmodule

// File: rtl/core_mem_port.sv
// Per-core load/store initiator: one-cycle memory strobes, one-cycle response, shared-write backoff.
module core_mem_port #(
  parameter int TAM     = nrisc_mem_pkg::TAM,
  parameter int Lmem    = nrisc_mem_pkg::Lmem,
  parameter int CORE_ID = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [TAM-1:0] req_addr,
  input  logic [TAM-1:0] req_wdata,
  output logic           resp_valid,
  output logic [TAM-1:0] resp_rdata,
  output logic           resp_err,
  output logic [TAM-1:0] mem_addr,
  output logic [TAM-1:0] mem_wdata,
  output logic           mem_load,
  output logic           mem_write,
  input  logic [TAM-1:0] mem_rdata,
  input  logic           peer_shwr
);
  import nrisc_mem_pkg::*;

  port_state_e    state_q, state_d;
  logic           req_ready_q, req_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_err_q, resp_err_d;
  logic [TAM-1:0] resp_rdata_q, resp_rdata_d;
  logic [TAM-1:0] mem_addr_q, mem_addr_d;
  logic [TAM-1:0] mem_wdata_q, mem_wdata_d;
  logic           mem_load_q, mem_load_d;
  logic           mem_write_q, mem_write_d;
  logic           err_q, err_d;
  logic           shared_q, shared_d;
  logic           is_shared, illegal;

  mem_addr_check #(.AW(TAM), .LW(Lmem)) u_chk (
    .addr      (req_addr),
    .we        (req_we),
    .is_shared (is_shared),
    .illegal   (illegal)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_load_d   = 1'b0;
    mem_write_d  = 1'b0;
    err_d        = err_q;
    shared_d     = shared_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = ISSUE;
          err_d    = illegal;
          shared_d = is_shared;
          // rejected requests still take the ISSUE slot, but never touch the memory
          if (!illegal) begin
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            mem_load_d  = ~req_we;
            mem_write_d = req_we;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        if (mem_load_q) resp_rdata_d = mem_rdata;
        // peer wrote shared memory in the same cycle: our write sits in the deferred slot
        if (CORE_ID == 1 && mem_write_q && shared_q && peer_shwr) begin
          state_d = HOLD;
        end else begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end
      HOLD: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_load_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      err_q        <= 1'b0;
      shared_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_load_q   <= mem_load_d;
      mem_write_q  <= mem_write_d;
      err_q        <= err_d;
      shared_q     <= shared_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_load   = mem_load_q;
  assign mem_write  = mem_write_q;
endmodule

// File: tb/tb_core_mem_port.sv
// Directed bench for core_mem_port: CORE_ID=0 and CORE_ID=1 instances share stimulus and memory.
module tb_core_mem_port;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        peer = 1'b0;
  logic [15:0] mem_rdata = '0;

  logic        rdy0, rv0, err0, ld0, wr0;
  logic [15:0] rd0, ma0, mw0;
  logic        rdy1, rv1, err1, ld1, wr1;
  logic [15:0] rd1, ma1, mw1;

  logic [15:0] mem [0:511];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_mem_port #(.TAM(16), .Lmem(8), .CORE_ID(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv0), .resp_rdata(rd0),
    .resp_err(err0), .mem_addr(ma0), .mem_wdata(mw0), .mem_load(ld0), .mem_write(wr0),
    .mem_rdata(mem_rdata), .peer_shwr(peer));

  core_mem_port #(.TAM(16), .Lmem(8), .CORE_ID(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(err1), .mem_addr(ma1), .mem_wdata(mw1), .mem_load(ld1), .mem_write(wr1),
    .mem_rdata(mem_rdata), .peer_shwr(peer));

  // memory samples the strobes during the low half of the clock
  always @(negedge clk) begin
    if (wr0) mem[ma0[8:0]] <= mw0;
    if (ld0) mem_rdata <= mem[ma0[8:0]];
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (rdy0 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 16'(rdy0), 16'd1);
  endtask

  task automatic do_req(int idx, vec_t v);
    logic el, ew;
    el = !v.exp_err && !v.we;
    ew = !v.exp_err && v.we;
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    check($sformatf("v%0d_load", idx),   16'(ld0), 16'(el));
    check($sformatf("v%0d_write", idx),  16'(wr0), 16'(ew));
    check($sformatf("v%0d_maddr", idx),  ma0, (el || ew) ? v.addr : 16'h0);
    check($sformatf("v%0d_mwdata", idx), mw0, (el || ew) ? v.wdata : 16'h0);
    check($sformatf("v%0d_busy", idx),   16'(rdy0), 16'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d_rvalid", idx), 16'(rv0), 16'd1);
    check($sformatf("v%0d_err", idx),    16'(err0), 16'(v.exp_err));
    check($sformatf("v%0d_rdata", idx),  rd0, v.exp_rdata);
    check($sformatf("v%0d_rdata1", idx), rd1, v.exp_rdata);
    check($sformatf("v%0d_strobes", idx), 16'({ld0, wr0}), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    mem[9'h005] = 16'hBEEF;
    mem[9'h100] = 16'h0A5A;

    //            we    addr      wdata     err   rdata
    vecs[0]  = '{1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
    vecs[1]  = '{1'b1, 16'h0105, 16'h1234, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b0, 16'h0105, 16'h0000, 1'b0, 16'h1234};
    vecs[3]  = '{1'b1, 16'h0100, 16'hDEAD, 1'b1, 16'h1234};
    vecs[4]  = '{1'b0, 16'h0200, 16'h0000, 1'b1, 16'h1234};
    vecs[5]  = '{1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0A5A};
    vecs[6]  = '{1'b1, 16'h0101, 16'h7777, 1'b0, 16'h0A5A};
    vecs[7]  = '{1'b0, 16'h0101, 16'h0000, 1'b0, 16'h7777};
    vecs[8]  = '{1'b0, 16'h8000, 16'h0000, 1'b1, 16'h7777};
    vecs[9]  = '{1'b1, 16'h00FF, 16'h5555, 1'b0, 16'h7777};
    vecs[10] = '{1'b0, 16'h00FF, 16'h0000, 1'b0, 16'h5555};

    #12;
    check("rst_ready", 16'(rdy0), 16'd1);
    check("rst_rvalid", 16'({rv0, rv1}), 16'd0);
    check("rst_err", 16'(err0), 16'd0);
    check("rst_rdata", rd0, 16'h0);
    check("rst_mem", 16'({ld0, wr0}), 16'd0);
    check("rst_maddr", ma0 | mw0, 16'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) do_req(i, vecs[i]);

    // back-to-back loads: accept every other edge, response alongside next acceptance
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b%0d_load", i),  16'(ld0), 16'((i % 2) == 0));
      check($sformatf("b2b%0d_rv", i),    16'(rv0), 16'((i % 2) == 1));
      check($sformatf("b2b%0d_ready", i), 16'(rdy0), 16'((i % 2) == 1));
    end
    check("b2b_rdata", rd0, 16'hBEEF);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;

    // shared store with peer conflict: only the CORE_ID=1 port backs off
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0110; req_wdata = 16'h4242; peer = 1'b1;
    @(posedge clk); #1;
    check("bo_issue_wr1", 16'(wr1), 16'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("bo_hold_ready1", 16'(rdy1), 16'd0);
    check("bo_hold_rv1", 16'(rv1), 16'd1);
    check("bo_hold_err1", 16'(err1), 16'd0);
    check("bo_hold_strobe1", 16'({ld1, wr1}), 16'd0);
    check("bo_noh_ready0", 16'(rdy0), 16'd1);
    check("bo_noh_rv0", 16'(rv0), 16'd1);
    @(posedge clk); #1;
    check("bo_after_ready1", 16'(rdy1), 16'd1);
    check("bo_after_rv1", 16'(rv1), 16'd0);
    peer = 1'b0;

    // legal shared store without conflict: no backoff on either port
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0111; req_wdata = 16'h1111; peer = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("nobo_ready1", 16'(rdy1), 16'd1);

    // reset in the middle of a store's ISSUE cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0120; req_wdata = 16'h9999;
    @(posedge clk); #1;
    check("rstmid_wr_before", 16'(wr0), 16'd1);
    #1;
    rst = 1'b0;
    #1;
    req_valid = 1'b0;
    check("rstmid_wr_drop", 16'({wr0, wr1}), 16'd0);
    check("rstmid_maddr", ma0, 16'h0);
    check("rstmid_ready", 16'(rdy0), 16'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_rv%0d", i), 16'({rv0, rv1}), 16'd0);
      check($sformatf("rstmid_rdy%0d", i), 16'({rdy0, rdy1}), 16'h3);
    end
    check("rstmid_memwrite", mem[9'h120], 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
